// File: rtl/gate_sweep_pkg.sv
// Shared types for the gate_sweep truth-table exerciser.
// Op codes, FSM states and the legal-op helper.
package gate_sweep_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_NAND = 3'b010,
        OP_NOR  = 3'b011,
        OP_XOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam int CNT_W = 4;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op != OP_RSV6) && (op != OP_RSV7);
    endfunction

endpackage

// File: rtl/gate_sweep_eval.sv
// gate_eval: combinational golden model of an N-input gate.
// Reserved op codes evaluate to 0.
module gate_eval
    import gate_sweep_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic [N_IN-1:0] i_stim,
    input  logic [2:0]      i_op,
    output logic            o_expected
);

    logic w_and;
    logic w_or;
    logic w_xor;

    assign w_and = &i_stim;
    assign w_or  = |i_stim;
    assign w_xor = ^i_stim;

    always_comb begin
        o_expected = 1'b0;
        case (op_t'(i_op))
            OP_AND:  o_expected = w_and;
            OP_OR:   o_expected = w_or;
            OP_NAND: o_expected = ~w_and;
            OP_NOR:  o_expected = ~w_or;
            OP_XOR:  o_expected = w_xor;
            OP_XNOR: o_expected = ~w_xor;
            default: o_expected = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_sweep.sv
// gate_sweep: drives every input vector into a gate under test and counts mismatches.
// GATE_SWEEP_FIRST_FAIL_EN adds capture of the first failing vector.
module gate_sweep
    import gate_sweep_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    output logic [N_IN-1:0]  stim,
    input  logic             gut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             bad_op,
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    output logic [ERR_W-1:0] err_cnt,
    output logic [N_IN-1:0]  first_fail_vec,
    output logic             first_fail_valid
`else
    output logic [ERR_W-1:0] err_cnt
`endif
);

    state_t            r_state;
    op_t               r_op;
    logic [CNT_W-1:0]  r_cnt;
    logic [N_IN-1:0]   r_stim;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic              r_bad_op;
    logic [ERR_W-1:0]  r_err;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    logic [N_IN-1:0]   r_ff_vec;
    logic              r_ff_valid;
`endif

    logic              w_exp;
    logic              w_mis;
    logic              w_last;
    logic              w_stim_max;
    logic [ERR_W-1:0]  w_err_nxt;

    gate_eval #(
        .N_IN (N_IN)
    ) u_eval (
        .i_stim     (r_stim),
        .i_op       (r_op),
        .o_expected (w_exp)
    );

    assign w_mis      = (gut_out != w_exp);
    assign w_last     = (r_cnt == CNT_W'(SETTLE - 1));
    assign w_stim_max = &r_stim;
    // Counter sticks at all-ones once saturated.
    assign w_err_nxt  = (w_mis && (r_err != '1)) ? r_err + 1'b1 : r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op       <= OP_AND;
            r_cnt      <= '0;
            r_stim     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_bad_op   <= 1'b0;
            r_err      <= '0;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
            r_ff_vec   <= '0;
            r_ff_valid <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_done <= 1'b0;
                        r_pass <= 1'b0;
                        r_err  <= '0;
                        r_stim <= '0;
                        r_cnt  <= '0;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
                        r_ff_vec   <= '0;
                        r_ff_valid <= 1'b0;
`endif
                        if (is_legal_op(op)) begin
                            r_state  <= S_RUN;
                            r_busy   <= 1'b1;
                            r_bad_op <= 1'b0;
                            r_op     <= op_t'(op);
                        end else begin
                            r_state  <= S_DONE;
                            r_bad_op <= 1'b1;
                            r_done   <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_last) begin
                        r_cnt <= '0;
                        r_err <= w_err_nxt;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
                        if (w_mis && !r_ff_valid) begin
                            r_ff_vec   <= r_stim;
                            r_ff_valid <= 1'b1;
                        end
`endif
                        if (w_stim_max) begin
                            r_state <= S_DONE;
                            r_stim  <= '0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_nxt == '0);
                        end else begin
                            r_stim <= r_stim + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stim    = r_stim;
    assign busy    = r_busy;
    assign done    = r_done;
    assign pass    = r_pass;
    assign bad_op  = r_bad_op;
    assign err_cnt = r_err;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    assign first_fail_vec   = r_ff_vec;
    assign first_fail_valid = r_ff_valid;
`endif

endmodule

// File: tb/tb_gate_sweep.sv
// Directed bench for gate_sweep: three instances cover 2-input/SETTLE=1,
// 3-input/SETTLE=3 and a 2-bit saturating error counter.
module tb_gate_sweep;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start2 = 1'b0;
    logic       start3 = 1'b0;
    logic       start4 = 1'b0;
    logic [2:0] op2 = 3'b000;
    logic [2:0] op3 = 3'b000;
    logic [2:0] op4 = 3'b000;
    logic       mode2 = 1'b0;

    logic [1:0] stim2;
    logic [2:0] stim3;
    logic [2:0] stim4;
    logic       gut2, gut3, gut4;
    logic       busy2, busy3, busy4;
    logic       done2, done3, done4;
    logic       pass2, pass3, pass4;
    logic       bad2, bad3, bad4;
    logic [7:0] err2, err3;
    logic [1:0] err4;
`ifdef GATE_SWEEP_FIRST_FAIL_EN
    logic [1:0] ffv2;
    logic [2:0] ffv3, ffv4;
    logic       ffok2, ffok3, ffok4;
`endif

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Gate models: correct NOR or stuck-at-0, an OR, an XNOR.
    assign gut2 = mode2 ? 1'b0 : ~|stim2;
    assign gut3 = |stim3;
    assign gut4 = ~^stim4;

    gate_sweep #(.N_IN(2), .SETTLE(1), .ERR_W(8)) u2 (
        .clk(clk), .rst(rst), .start(start2), .op(op2),
        .stim(stim2), .gut_out(gut2), .busy(busy2), .done(done2),
        .pass(pass2), .bad_op(bad2),
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        .first_fail_vec(ffv2), .first_fail_valid(ffok2),
`endif
        .err_cnt(err2)
    );

    gate_sweep #(.N_IN(3), .SETTLE(3), .ERR_W(8)) u3 (
        .clk(clk), .rst(rst), .start(start3), .op(op3),
        .stim(stim3), .gut_out(gut3), .busy(busy3), .done(done3),
        .pass(pass3), .bad_op(bad3),
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        .first_fail_vec(ffv3), .first_fail_valid(ffok3),
`endif
        .err_cnt(err3)
    );

    gate_sweep #(.N_IN(3), .SETTLE(1), .ERR_W(2)) u4 (
        .clk(clk), .rst(rst), .start(start4), .op(op4),
        .stim(stim4), .gut_out(gut4), .busy(busy4), .done(done4),
        .pass(pass4), .bad_op(bad4),
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        .first_fail_vec(ffv4), .first_fail_valid(ffok4),
`endif
        .err_cnt(err4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        repeat (2) step();
        rst = 1'b0;
        chk("rst_stim", 32'(stim2), 0);
        chk("rst_busy", 32'(busy2), 0);
        chk("rst_done", 32'(done2), 0);
        chk("rst_pass", 32'(pass2), 0);
        chk("rst_bad", 32'(bad2), 0);
        chk("rst_err", 32'(err2), 0);
        chk("rst_busy3", 32'(busy3), 0);

        // Correct NOR, one vector per cycle
        op2 = 3'b011;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        chk("nor_busy", 32'(busy2), 1);
        chk("nor_v0", 32'(stim2), 0);
        chk("nor_done0", 32'(done2), 0);
        step();
        chk("nor_v1", 32'(stim2), 1);
        step();
        chk("nor_v2", 32'(stim2), 2);
        step();
        chk("nor_v3", 32'(stim2), 3);
        chk("nor_busy3", 32'(busy2), 1);
        step();
        chk("nor_done", 32'(done2), 1);
        chk("nor_busyoff", 32'(busy2), 0);
        chk("nor_pass", 32'(pass2), 1);
        chk("nor_err", 32'(err2), 0);
        chk("nor_stim0", 32'(stim2), 0);
        chk("nor_bad", 32'(bad2), 0);

        // Stuck-at-0 GUT, restarted from DONE
        mode2 = 1'b1;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        chk("sa0_donefall", 32'(done2), 0);
        chk("sa0_busy", 32'(busy2), 1);
        repeat (4) step();
        chk("sa0_done", 32'(done2), 1);
        chk("sa0_err", 32'(err2), 1);
        chk("sa0_pass", 32'(pass2), 0);
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        chk("sa0_ffv", 32'(ffv2), 0);
        chk("sa0_ffok", 32'(ffok2), 1);
`endif

        // Reserved op
        op2 = 3'b110;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        chk("rsv_done", 32'(done2), 1);
        chk("rsv_bad", 32'(bad2), 1);
        chk("rsv_busy", 32'(busy2), 0);
        chk("rsv_pass", 32'(pass2), 0);
        chk("rsv_stim", 32'(stim2), 0);
        chk("rsv_err", 32'(err2), 0);
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        chk("rsv_ffok", 32'(ffok2), 0);
`endif
        step();
        chk("rsv_busy2", 32'(busy2), 0);
        chk("rsv_done2", 32'(done2), 1);

        // AND expected, OR GUT, SETTLE=3
        op3 = 3'b000;
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        chk("and_busy", 32'(busy3), 1);
        chk("and_v0", 32'(stim3), 0);
        step();
        step();
        chk("and_hold", 32'(stim3), 0);
        step();
        chk("and_v1", 32'(stim3), 1);
        repeat (20) step();
        chk("and_v7", 32'(stim3), 7);
        chk("and_done0", 32'(done3), 0);
        step();
        chk("and_done", 32'(done3), 1);
        chk("and_err", 32'(err3), 6);
        chk("and_pass", 32'(pass3), 0);
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        chk("and_ffv", 32'(ffv3), 1);
        chk("and_ffok", 32'(ffok3), 1);
`endif

        // XOR expected, XNOR GUT, 2-bit counter saturates
        op4 = 3'b100;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        repeat (3) step();
        chk("sat_err3", 32'(err4), 3);
        repeat (2) step();
        chk("sat_hold", 32'(err4), 3);
        chk("sat_busy", 32'(busy4), 1);
        repeat (3) step();
        chk("sat_done", 32'(done4), 1);
        chk("sat_err", 32'(err4), 3);
        chk("sat_pass", 32'(pass4), 0);

        // Reset mid-sweep, then clean sweep with start held high
        op2 = 3'b011;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        step();
        step();
        chk("mid_v2", 32'(stim2), 2);
        chk("mid_err", 32'(err2), 1);
        rst = 1'b1;
        start2 = 1'b1;
        step();
        chk("mrst_stim", 32'(stim2), 0);
        chk("mrst_busy", 32'(busy2), 0);
        chk("mrst_done", 32'(done2), 0);
        chk("mrst_pass", 32'(pass2), 0);
        chk("mrst_bad", 32'(bad2), 0);
        chk("mrst_err", 32'(err2), 0);
`ifdef GATE_SWEEP_FIRST_FAIL_EN
        chk("mrst_ffok", 32'(ffok2), 0);
`endif
        rst = 1'b0;
        mode2 = 1'b0;
        step();
        chk("re_busy", 32'(busy2), 1);
        chk("re_v0", 32'(stim2), 0);
        op2 = 3'b110;
        step();
        chk("re_v1", 32'(stim2), 1);
        step();
        chk("re_v2", 32'(stim2), 2);
        step();
        chk("re_v3", 32'(stim2), 3);
        start2 = 1'b0;
        step();
        chk("re_done", 32'(done2), 1);
        chk("re_pass", 32'(pass2), 1);
        chk("re_bad", 32'(bad2), 0);
        chk("re_err", 32'(err2), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
